// File: rtl/comp_pkg.sv
// Shared definitions for the sequential chunked comparator: op and state
// encodings, chunk-count derivation and the signed-op classifier.
package comp_pkg;

    typedef enum logic [2:0] {
        OP_EQ  = 3'b000,
        OP_NE  = 3'b001,
        OP_LT  = 3'b010,
        OP_GE  = 3'b011,
        OP_LTU = 3'b100,
        OP_GEU = 3'b101,
        OP_MAX = 3'b110,
        OP_MIN = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SCAN = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Number of CHUNK-wide slices in a WIDTH-wide operand.
    function automatic int nchunk(input int width, input int chunk);
        return (chunk > 0) ? (width / chunk) : 1;
    endfunction

    // Width of the slice index register (at least one bit).
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Ops that treat the operands as two's-complement numbers.
    function automatic logic is_signed_op(input op_e op);
        logic sgn;
        case (op)
            OP_LT, OP_GE, OP_MAX, OP_MIN: sgn = 1'b1;
            default:                      sgn = 1'b0;
        endcase
        return sgn;
    endfunction

endpackage

// File: rtl/comp_chunk.sv
// Combinational magnitude compare of one unsigned slice.
module comp_chunk #(
    parameter int CHUNK = 16
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    output logic             lt,
    output logic             gt
);

    assign lt = (a < b);
    assign gt = (a > b);

endmodule

// File: rtl/comp_seq.sv
// Sequential comparator: scans CHUNK-wide slices MSB-first, exits early on
// the first differing slice, and holds the result until it is consumed.
module comp_seq
    import comp_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] outp,
    output logic             lt,
    output logic             eq,
    output logic             gt
);

    localparam int NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int IDXW   = idx_bits(NCHUNK);
    localparam logic [IDXW-1:0]  TOP_IDX   = IDXW'(NCHUNK - 1);
    localparam logic [WIDTH-1:0] SIGN_MASK = {1'b1, {(WIDTH-1){1'b0}}};

    if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
        $error("comp_seq: CHUNK must divide WIDTH and not exceed it");
    end

    // Registered state
    state_e           state_r;
    logic [IDXW-1:0]  idx_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    op_e              op_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] outp_r;
    logic             lt_r;
    logic             eq_r;
    logic             gt_r;

    // Next-state values
    state_e           state_nxt_s;
    logic [IDXW-1:0]  idx_nxt_s;
    logic [WIDTH-1:0] a_nxt_s;
    logic [WIDTH-1:0] b_nxt_s;
    op_e              op_nxt_s;
    logic             in_ready_nxt_s;
    logic             out_valid_nxt_s;
    logic [WIDTH-1:0] outp_nxt_s;
    logic             lt_nxt_s;
    logic             eq_nxt_s;
    logic             gt_nxt_s;

    // Slice datapath
    logic [WIDTH-1:0]             a_cmp_s;
    logic [WIDTH-1:0]             b_cmp_s;
    logic [NCHUNK-1:0][CHUNK-1:0] a_arr_s;
    logic [NCHUNK-1:0][CHUNK-1:0] b_arr_s;
    logic [CHUNK-1:0]             a_sl_s;
    logic [CHUNK-1:0]             b_sl_s;
    logic                         sl_lt_s;
    logic                         sl_gt_s;

    // Final result word for an op given the overall relation of A to B.
    function automatic logic [WIDTH-1:0] result_of(input op_e o, input logic rlt,
                                                   input logic rgt,
                                                   input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        r = '0;
        case (o)
            OP_EQ:         r[0] = ~rlt & ~rgt;
            OP_NE:         r[0] = rlt | rgt;
            OP_LT, OP_LTU: r[0] = rlt;
            OP_GE, OP_GEU: r[0] = ~rlt;
            OP_MAX:        r = rgt ? a : (rlt ? b : a);
            OP_MIN:        r = rlt ? a : (rgt ? b : a);
            default:       r = '0;
        endcase
        return r;
    endfunction

    // Flip the sign bits for signed ops so an unsigned slice compare orders them.
    always_comb begin
        a_cmp_s = a_r;
        b_cmp_s = b_r;
        if (is_signed_op(op_r)) begin
            a_cmp_s = a_r ^ SIGN_MASK;
            b_cmp_s = b_r ^ SIGN_MASK;
        end else begin
            a_cmp_s = a_r;
            b_cmp_s = b_r;
        end
    end

    assign a_arr_s = a_cmp_s;
    assign b_arr_s = b_cmp_s;
    assign a_sl_s  = a_arr_s[idx_r];
    assign b_sl_s  = b_arr_s[idx_r];

    comp_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a  (a_sl_s),
        .b  (b_sl_s),
        .lt (sl_lt_s),
        .gt (sl_gt_s)
    );

    // Next-state and next-output logic of the IDLE/SCAN/DONE controller.
    always_comb begin
        state_nxt_s     = state_r;
        idx_nxt_s       = idx_r;
        a_nxt_s         = a_r;
        b_nxt_s         = b_r;
        op_nxt_s        = op_r;
        in_ready_nxt_s  = in_ready_r;
        out_valid_nxt_s = out_valid_r;
        outp_nxt_s      = outp_r;
        lt_nxt_s        = lt_r;
        eq_nxt_s        = eq_r;
        gt_nxt_s        = gt_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    a_nxt_s        = A;
                    b_nxt_s        = B;
                    op_nxt_s       = op_e'(op);
                    idx_nxt_s      = TOP_IDX;
                    lt_nxt_s       = 1'b0;
                    eq_nxt_s       = 1'b0;
                    gt_nxt_s       = 1'b0;
                    in_ready_nxt_s = 1'b0;
                    state_nxt_s    = ST_SCAN;
                end else begin
                    in_ready_nxt_s = 1'b1;
                end
            end
            ST_SCAN: begin
                if (sl_lt_s || sl_gt_s) begin
                    lt_nxt_s        = sl_lt_s;
                    gt_nxt_s        = sl_gt_s;
                    eq_nxt_s        = 1'b0;
                    outp_nxt_s      = result_of(op_r, sl_lt_s, sl_gt_s, a_r, b_r);
                    out_valid_nxt_s = 1'b1;
                    state_nxt_s     = ST_DONE;
                end else if (idx_r == IDXW'(0)) begin
                    lt_nxt_s        = 1'b0;
                    gt_nxt_s        = 1'b0;
                    eq_nxt_s        = 1'b1;
                    outp_nxt_s      = result_of(op_r, 1'b0, 1'b0, a_r, b_r);
                    out_valid_nxt_s = 1'b1;
                    state_nxt_s     = ST_DONE;
                end else begin
                    idx_nxt_s = idx_r - IDXW'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_nxt_s = 1'b0;
                    in_ready_nxt_s  = 1'b1;
                    state_nxt_s     = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                out_valid_nxt_s = 1'b0;
                in_ready_nxt_s  = 1'b1;
                idx_nxt_s       = TOP_IDX;
                state_nxt_s     = ST_IDLE;
            end
        endcase
    end

    // State, captured operands and registered outputs; reset drops any request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            idx_r       <= TOP_IDX;
            a_r         <= '0;
            b_r         <= '0;
            op_r        <= OP_EQ;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            outp_r      <= '0;
            lt_r        <= 1'b0;
            eq_r        <= 1'b0;
            gt_r        <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            idx_r       <= idx_nxt_s;
            a_r         <= a_nxt_s;
            b_r         <= b_nxt_s;
            op_r        <= op_nxt_s;
            in_ready_r  <= in_ready_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            outp_r      <= outp_nxt_s;
            lt_r        <= lt_nxt_s;
            eq_r        <= eq_nxt_s;
            gt_r        <= gt_nxt_s;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign outp      = outp_r;
    assign lt        = lt_r;
    assign eq        = eq_r;
    assign gt        = gt_r;

endmodule

// File: tb/tb_comp_seq.sv
// Self-checking bench for comp_seq: directed cases plus randomized requests
// checked against an arithmetic reference model.
module tb_comp_seq;

    localparam int WIDTH = 64;
    localparam int CHUNK = 16;
    localparam int NCH   = WIDTH / CHUNK;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] outp;
    logic             lt;
    logic             eq;
    logic             gt;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    comp_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .outp      (outp),
        .lt        (lt),
        .eq        (eq),
        .gt        (gt)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                         input logic [WIDTH-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plain signed/unsigned arithmetic; k = slices examined.
    task automatic model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [2:0] o, output logic [WIDTH-1:0] r,
                         output logic rl, output logic re, output logic rg,
                         output int k);
        logic             sgn;
        logic [WIDTH-1:0] d;
        logic             found;
        sgn = (o == 3'd2) || (o == 3'd3) || (o == 3'd6) || (o == 3'd7);
        if (sgn) begin
            rl = ($signed(a) < $signed(b));
            rg = ($signed(a) > $signed(b));
        end else begin
            rl = (a < b);
            rg = (a > b);
        end
        re = (a == b);
        r = '0;
        case (o)
            3'd0: r[0] = re;
            3'd1: r[0] = !re;
            3'd2: r[0] = rl;
            3'd3: r[0] = !rl;
            3'd4: r[0] = rl;
            3'd5: r[0] = !rl;
            3'd6: r = (rg || re) ? a : b;
            default: r = (rl || re) ? a : b;
        endcase
        d = a ^ b;
        k = NCH;
        found = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (!found && ((d >> (i * CHUNK)) & {{(WIDTH-CHUNK){1'b0}}, {CHUNK{1'b1}}}) != '0) begin
                k = NCH - i;
                found = 1'b1;
            end
        end
    endtask

    // One full request: accept, wait for result, hold in DONE, then consume.
    task automatic run_txn(input string tag, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b, input logic [2:0] o,
                           input int hold);
        logic [WIDTH-1:0] er;
        logic el, ee, eg;
        int k;
        int cyc;
        model(a, b, o, er, el, ee, eg, k);
        check({tag, ".in_ready"}, WIDTH'(in_ready), WIDTH'(1));
        A = a; B = b; op = o; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        A = {$urandom, $urandom};
        B = {$urandom, $urandom};
        op = 3'($urandom_range(0, 7));
        cyc = 1;
        check({tag, ".busy"}, WIDTH'(in_ready), WIDTH'(0));
        while (out_valid !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, ".latency"}, WIDTH'(cyc), WIDTH'(k + 1));
        check({tag, ".outp"}, outp, er);
        check({tag, ".rel"}, WIDTH'({lt, eq, gt}), WIDTH'({el, ee, eg}));
        for (int h = 0; h < hold; h++) begin
            in_valid = h[0];
            A = {$urandom, $urandom};
            B = {$urandom, $urandom};
            @(negedge clk);
            check({tag, ".hold_flags"}, WIDTH'({out_valid, in_ready, lt, eq, gt}),
                  WIDTH'({1'b1, 1'b0, el, ee, eg}));
            check({tag, ".hold_outp"}, outp, er);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, ".handshake"}, WIDTH'({out_valid, in_ready}), WIDTH'(2'b01));
    endtask

    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic [WIDTH-1:0] mask;
        int sh;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        A = '0; B = '0; op = 3'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset.flags", WIDTH'({in_ready, out_valid, lt, eq, gt}), WIDTH'(5'b10000));
        check("reset.outp", outp, '0);

        run_txn("ltu_top", 64'hAAAA_BBBB_CCCC_DDDD, 64'h1111_2222_3333_4444, 3'd4, 0);
        run_txn("lt_zero", 64'h0, 64'h1111_2222_3333_4554, 3'd2, 0);
        run_txn("lt_neg", 64'hAAAA_AAAA_AAAA_AAAA, 64'h1111_2222_3333_4444, 3'd2, 0);
        run_txn("ltu_neg", 64'hAAAA_AAAA_AAAA_AAAA, 64'h1111_2222_3333_4444, 3'd4, 0);
        run_txn("eq_full", 64'h1111_2222_3333_4444, 64'h1111_2222_3333_4444, 3'd0, 0);
        run_txn("ne_bit0", 64'h1111_2222_3333_4444, 64'h1111_2222_3333_4445, 3'd1, 0);
        run_txn("max", 64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB, 3'd6, 0);
        run_txn("min", 64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB, 3'd7, 0);
        run_txn("max_eq", 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 3'd6, 0);
        run_txn("min_sgn", 64'h7FFF_0000_0000_0000, 64'h8000_0000_0000_0000, 3'd7, 0);
        run_txn("geu_eq", 64'h5, 64'h5, 3'd5, 0);
        run_txn("ge_neg", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 3'd3, 0);
        run_txn("done_hold", 64'h1234_0000_0000_0000, 64'h1234_5678_0000_0000, 3'd2, 10);

        // Reset during the second SCAN cycle discards the request.
        check("rst_mid.in_ready", WIDTH'(in_ready), WIDTH'(1));
        A = 64'h1111_2222_3333_4444; B = A; op = 3'd0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid.flags", WIDTH'({in_ready, out_valid, lt, eq, gt}), WIDTH'(5'b10000));
        check("rst_mid.outp", outp, '0);
        run_txn("after_rst", 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0000, 3'd6, 1);

        for (int n = 0; n < 48; n++) begin
            ra = {$urandom, $urandom};
            sh = $urandom_range(0, NCH);
            mask = '0;
            for (int c = 0; c < sh; c++) begin
                mask = mask | ({{(WIDTH-CHUNK){1'b0}}, {CHUNK{1'b1}}} << ((NCH - 1 - c) * CHUNK));
            end
            rb = (ra & mask) | ({$urandom, $urandom} & ~mask);
            run_txn("rand", ra, rb, 3'($urandom_range(0, 7)), $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
